// File: rtl/fejkon_mem_access_pkg.sv
// Shared definitions for the PCIe memory-access bridge: record field offsets,
// completion status and FSM state encodings, and the completion packer.
package fejkon_mem_access_pkg;

    localparam int REQ_ADDR_LSB   = 0;
    localparam int REQ_WDATA_LSB  = 64;
    localparam int REQ_TAG_LSB    = 96;
    localparam int REQ_RID_LSB    = 104;
    localparam int REQ_BE_LSB     = 120;
    localparam int REQ_IS_WRITE   = 124;
    localparam int TAG_W          = 8;
    localparam int RID_W          = 16;
    localparam int LOADDR_W       = 7;

    localparam logic [31:0] DATA_ERR = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_UR      = 2'b01,
        ST_TIMEOUT = 2'b10,
        ST_RSVD    = 2'b11
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_WAIT_RD,
        S_RESP
    } state_e;

    // Completion layout: bit 63 and [127:66] are always zero.
    function automatic logic [127:0] make_resp(input logic [31:0]       data,
                                               input logic [TAG_W-1:0]  tag,
                                               input logic [RID_W-1:0]  rid,
                                               input logic [LOADDR_W-1:0] lo_addr,
                                               input status_e           st);
        return {62'b0, st, 1'b0, lo_addr, rid, tag, data};
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/fejkon_mem_access_timeout.sv
// Bus-timeout down-counter: loaded on command issue, decrements while the
// bridge is busy, and flags expiry at terminal count zero.
module fejkon_mem_access_timeout #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_load,
    input  logic i_run,
    output logic o_expired
);

    localparam logic [15:0] LOAD_VAL = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= 16'd0;
        end else if (i_load) begin
            r_count <= LOAD_VAL;
        end else if (i_run && (r_count != 16'd0)) begin
            r_count <= r_count - 16'd1;
        end
    end

    // Loaded with N-1 so expiry fires on the N-th busy cycle.
    assign o_expired = i_run && (r_count == 16'd0);

endmodule

// File: rtl/fejkon_pcie_mem_access.sv
// Bridges TLP memory requests to a single-word Avalon-MM master and returns
// read completions. Optional bus timeout: FEJKON_MEM_ACCESS_TIMEOUT_EN.
//
// state     | meaning
// S_IDLE    | req_ready high, waiting for a request
// S_CMD     | avm_read/avm_write asserted until waitrequest drops
// S_WAIT_RD | read accepted by slave, waiting for readdatavalid
// S_RESP    | resp_valid high, holding completion until resp_ready
module fejkon_pcie_mem_access
    import fejkon_mem_access_pkg::*;
#(
    parameter int AVM_ADDR_W     = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [127:0]          req_data,
    input  logic                  req_valid,
    output logic                  req_ready,
    output logic [127:0]          resp_data,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [AVM_ADDR_W-1:0] avm_address,
    output logic                  avm_read,
    output logic                  avm_write,
    output logic [31:0]           avm_writedata,
    output logic [3:0]            avm_byteenable,
    input  logic                  avm_waitrequest,
    input  logic [31:0]           avm_readdata,
    input  logic                  avm_readdatavalid,
    input  logic [1:0]            avm_response,
    output logic [15:0]           stat_dropped
);

    state_e                r_state;
    logic                  r_req_ready;
    logic                  r_resp_valid;
    logic [127:0]          r_resp_data;
    logic [AVM_ADDR_W-1:0] r_avm_address;
    logic                  r_avm_read;
    logic                  r_avm_write;
    logic [31:0]           r_avm_writedata;
    logic [3:0]            r_avm_byteenable;
    logic [15:0]           r_stat_dropped;
    logic [TAG_W-1:0]      r_tag;
    logic [RID_W-1:0]      r_rid;
    logic [LOADDR_W-1:0]   r_lo_addr;

    logic [63:0]           w_addr;
    logic                  w_is_write;
    logic                  w_accept;
    logic                  w_out_of_range;
    logic                  w_rdv;
    logic                  w_expired;
    logic [2:0]            w_unused_rsvd;

    assign w_addr         = req_data[REQ_ADDR_LSB +: 64];
    assign w_is_write     = req_data[REQ_IS_WRITE];
    assign w_accept       = req_valid && r_req_ready;
    assign w_out_of_range = |w_addr[63:AVM_ADDR_W];
    assign w_unused_rsvd  = req_data[127:125];

`ifdef FEJKON_MEM_ACCESS_TIMEOUT_EN
    logic r_stale;

    fejkon_mem_access_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_load    (w_accept && !w_out_of_range),
        .i_run     ((r_state == S_CMD) || (r_state == S_WAIT_RD)),
        .o_expired (w_expired)
    );

    // A read abandoned by timeout may still return data later; swallow it once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stale <= 1'b0;
        end else if ((r_state == S_WAIT_RD) && w_expired && !w_rdv) begin
            r_stale <= 1'b1;
        end else if (avm_readdatavalid) begin
            r_stale <= 1'b0;
        end
    end

    assign w_rdv = avm_readdatavalid && !r_stale;
`else
    logic [15:0] w_unused_cfg;
    assign w_unused_cfg = 16'(TIMEOUT_CYCLES);
    assign w_expired    = 1'b0;
    assign w_rdv        = avm_readdatavalid;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= S_IDLE;
            r_req_ready      <= 1'b0;
            r_resp_valid     <= 1'b0;
            r_resp_data      <= '0;
            r_avm_address    <= '0;
            r_avm_read       <= 1'b0;
            r_avm_write      <= 1'b0;
            r_avm_writedata  <= '0;
            r_avm_byteenable <= '0;
            r_stat_dropped   <= '0;
            r_tag            <= '0;
            r_rid            <= '0;
            r_lo_addr        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        r_tag     <= req_data[REQ_TAG_LSB +: TAG_W];
                        r_rid     <= req_data[REQ_RID_LSB +: RID_W];
                        r_lo_addr <= w_addr[LOADDR_W-1:0];
                        if (!w_out_of_range) begin
                            r_avm_address    <= {w_addr[AVM_ADDR_W-1:2], 2'b00};
                            r_avm_read       <= !w_is_write;
                            r_avm_write      <= w_is_write;
                            r_avm_writedata  <= req_data[REQ_WDATA_LSB +: 32];
                            r_avm_byteenable <= req_data[REQ_BE_LSB +: 4];
                            r_req_ready      <= 1'b0;
                            r_state          <= S_CMD;
                        end else if (w_is_write) begin
                            r_stat_dropped <= sat_inc(r_stat_dropped);
                        end else begin
                            r_resp_data  <= make_resp(DATA_ERR,
                                                      req_data[REQ_TAG_LSB +: TAG_W],
                                                      req_data[REQ_RID_LSB +: RID_W],
                                                      w_addr[LOADDR_W-1:0], ST_UR);
                            r_resp_valid <= 1'b1;
                            r_req_ready  <= 1'b0;
                            r_state      <= S_RESP;
                        end
                    end
                end
                S_CMD: begin
                    if (!avm_waitrequest) begin
                        r_avm_read  <= 1'b0;
                        r_avm_write <= 1'b0;
                        if (r_avm_write) begin
                            r_req_ready <= 1'b1;
                            r_state     <= S_IDLE;
                        end else begin
                            r_state <= S_WAIT_RD;
                        end
                    end else if (w_expired) begin
                        r_avm_read  <= 1'b0;
                        r_avm_write <= 1'b0;
                        if (r_avm_write) begin
                            r_stat_dropped <= sat_inc(r_stat_dropped);
                            r_req_ready    <= 1'b1;
                            r_state        <= S_IDLE;
                        end else begin
                            r_resp_data  <= make_resp(DATA_ERR, r_tag, r_rid, r_lo_addr, ST_TIMEOUT);
                            r_resp_valid <= 1'b1;
                            r_state      <= S_RESP;
                        end
                    end
                end
                S_WAIT_RD: begin
                    if (w_rdv) begin
                        r_resp_data  <= make_resp(avm_readdata, r_tag, r_rid, r_lo_addr,
                                                  (avm_response == 2'b00) ? ST_OK : ST_UR);
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end else if (w_expired) begin
                        r_resp_data  <= make_resp(DATA_ERR, r_tag, r_rid, r_lo_addr, ST_TIMEOUT);
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready      = r_req_ready;
    assign resp_valid     = r_resp_valid;
    assign resp_data      = r_resp_data;
    assign avm_address    = r_avm_address;
    assign avm_read       = r_avm_read;
    assign avm_write      = r_avm_write;
    assign avm_writedata  = r_avm_writedata;
    assign avm_byteenable = r_avm_byteenable;
    assign stat_dropped   = r_stat_dropped;

endmodule

// File: tb/tb_fejkon_pcie_mem_access.sv
// Directed self-checking bench for fejkon_pcie_mem_access; timeout scenario
// is compiled in when FEJKON_MEM_ACCESS_TIMEOUT_EN is defined.
module tb_fejkon_pcie_mem_access;

    logic         clk;
    logic         reset_n;
    logic [127:0] req_data;
    logic         req_valid;
    logic         req_ready;
    logic [127:0] resp_data;
    logic         resp_valid;
    logic         resp_ready;
    logic [15:0]  avm_address;
    logic         avm_read;
    logic         avm_write;
    logic [31:0]  avm_writedata;
    logic [3:0]   avm_byteenable;
    logic         avm_waitrequest;
    logic [31:0]  avm_readdata;
    logic         avm_readdatavalid;
    logic [1:0]   avm_response;
    logic [15:0]  stat_dropped;

    int checks = 0;
    int errors = 0;

    fejkon_pcie_mem_access #(
        .AVM_ADDR_W     (16),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .req_data          (req_data),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .resp_data         (resp_data),
        .resp_valid        (resp_valid),
        .resp_ready        (resp_ready),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_byteenable    (avm_byteenable),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .avm_response      (avm_response),
        .stat_dropped      (stat_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] mk_req(input logic [63:0] addr, input logic [31:0] wdata,
                                            input logic [7:0] tag, input logic [15:0] rid,
                                            input logic [3:0] be, input logic is_wr);
        return {3'b000, is_wr, be, rid, tag, wdata, addr};
    endfunction

    function automatic logic [127:0] exp_resp(input logic [31:0] data, input logic [7:0] tag,
                                              input logic [15:0] rid, input logic [6:0] lo,
                                              input logic [1:0] st);
        return {62'b0, st, 1'b0, lo, rid, tag, data};
    endfunction

    task automatic test_reset();
        reset_n = 1'b1;
        #3 reset_n = 1'b0;
        tick();
        tick();
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        checks++; if ({avm_read, avm_write} !== 2'b00) begin errors++; $display("FAIL reset_avm_cmd: got %b want 00", {avm_read, avm_write}); end
        checks++; if (resp_data !== 128'h0) begin errors++; $display("FAIL reset_resp_data: got %h want 0", resp_data); end
        checks++; if (stat_dropped !== 16'h0) begin errors++; $display("FAIL reset_stat_dropped: got %h want 0", stat_dropped); end
        reset_n = 1'b1;
        tick();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_read();
        req_data  = mk_req(64'h10, 32'h0, 8'h2A, 16'h0100, 4'hF, 1'b0);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        checks++; if (avm_read !== 1'b1 || avm_address !== 16'h0010) begin errors++; $display("FAIL read_cmd: got rd=%b addr=%h want rd=1 addr=0010", avm_read, avm_address); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL read_busy_ready: got %b want 0", req_ready); end
        tick();
        checks++; if (avm_read !== 1'b0) begin errors++; $display("FAIL read_cmd_drop: got %b want 0", avm_read); end
        tick();
        tick();
        avm_readdata      = 32'hDEADBEEF;
        avm_response      = 2'b00;
        avm_readdatavalid = 1'b1;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL read_early_resp: got %b want 0", resp_valid); end
        tick();
        avm_readdatavalid = 1'b0;
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL read_resp_valid: got %b want 1", resp_valid); end
        checks++; if (resp_data !== 128'h0000_0000_0000_0000_1001_002A_DEAD_BEEF) begin errors++; $display("FAIL read_resp_data: got %h want 1001002adeadbeef", resp_data); end
        resp_ready = 1'b1;
        tick();
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL read_handshake: got valid=%b ready=%b want 0/1", resp_valid, req_ready); end
        resp_ready = 1'b0;
    endtask

    task automatic test_write();
        int n_high;
        n_high = 0;
        avm_waitrequest = 1'b1;
        req_data  = mk_req(64'h8, 32'h12345678, 8'h01, 16'h0002, 4'hF, 1'b1);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        checks++; if (avm_address !== 16'h0008 || avm_writedata !== 32'h12345678 || avm_byteenable !== 4'hF) begin
            errors++; $display("FAIL write_cmd_fields: got addr=%h wd=%h be=%h want 0008/12345678/f", avm_address, avm_writedata, avm_byteenable);
        end
        for (int i = 0; i < 8; i++) begin
            if (i == 5) avm_waitrequest = 1'b0;
            if (avm_write === 1'b1) n_high++;
            checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL write_no_resp: cycle %0d got %b want 0", i, resp_valid); end
            tick();
        end
        checks++; if (n_high !== 6) begin errors++; $display("FAIL write_hold_cycles: got %0d want 6", n_high); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL write_ready_after: got %b want 1", req_ready); end
    endtask

    task automatic test_out_of_range();
        req_data  = mk_req(64'h1_0000_0000, 32'h0, 8'h55, 16'h1234, 4'hF, 1'b0);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        checks++; if (avm_read !== 1'b0 || avm_write !== 1'b0) begin errors++; $display("FAIL oor_no_bus: got rd=%b wr=%b want 0/0", avm_read, avm_write); end
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL oor_resp_valid: got %b want 1", resp_valid); end
        checks++; if (resp_data !== 128'h0000_0000_0000_0001_0012_3455_FFFF_FFFF) begin errors++; $display("FAIL oor_resp_data: got %h want 100123455ffffffff", resp_data); end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        req_data  = mk_req(64'h1_0000_0000, 32'hAAAA5555, 8'h56, 16'h1234, 4'hF, 1'b1);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        checks++; if (stat_dropped !== 16'd1) begin errors++; $display("FAIL oor_dropped: got %0d want 1", stat_dropped); end
        checks++; if (avm_write !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL oor_write_idle: got wr=%b valid=%b ready=%b want 0/0/1", avm_write, resp_valid, req_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd_vals [3];
        rd_vals[0] = 32'h0000_0001;
        rd_vals[1] = 32'h8000_0000;
        rd_vals[2] = 32'h5A5A_A5A5;
        resp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: read %0d got %b want 1", k, req_ready); end
            req_data  = mk_req(64'h100 + 64'(k * 4) + 64'h3, 32'h0, 8'(k + 8'h40), 16'hABCD, 4'hF, 1'b0);
            req_valid = 1'b1;
            tick();
            req_valid = 1'b0;
            checks++; if (avm_read !== 1'b1 || avm_address !== 16'(16'h100 + k * 4)) begin
                errors++; $display("FAIL b2b_cmd: read %0d got rd=%b addr=%h", k, avm_read, avm_address);
            end
            tick();
            avm_readdata      = rd_vals[k];
            avm_response      = 2'b00;
            avm_readdatavalid = 1'b1;
            tick();
            avm_readdatavalid = 1'b0;
            checks++; if (resp_valid !== 1'b1 || resp_data !== exp_resp(rd_vals[k], 8'(k + 8'h40), 16'hABCD, 7'(7'h03 + k * 4), 2'b00)) begin
                errors++; $display("FAIL b2b_resp: read %0d got valid=%b data=%h", k, resp_valid, resp_data);
            end
            tick();
        end
        req_data  = mk_req(64'h40, 32'hCAFE0001, 8'h00, 16'h0000, 4'h3, 1'b1);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        checks++; if (avm_write !== 1'b1 || avm_byteenable !== 4'h3) begin errors++; $display("FAIL b2b_write_cmd: got wr=%b be=%h want 1/3", avm_write, avm_byteenable); end
        tick();
        checks++; if (req_ready !== 1'b1 || avm_write !== 1'b0) begin errors++; $display("FAIL b2b_write_ready: got ready=%b wr=%b want 1/0", req_ready, avm_write); end
        resp_ready = 1'b0;
    endtask

    task automatic test_resp_backpressure();
        logic [127:0] want;
        want = exp_resp(32'hCAFEF00D, 8'h07, 16'hBEEF, 7'h24, 2'b01);
        resp_ready = 1'b0;
        req_data   = mk_req(64'h24, 32'h0, 8'h07, 16'hBEEF, 4'hF, 1'b0);
        req_valid  = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        avm_readdata      = 32'hCAFEF00D;
        avm_response      = 2'b10;
        avm_readdatavalid = 1'b1;
        tick();
        avm_readdatavalid = 1'b0;
        avm_response      = 2'b00;
        for (int i = 0; i < 10; i++) begin
            checks++; if (resp_valid !== 1'b1 || resp_data !== want || req_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold: cycle %0d got valid=%b ready=%b data=%h want 1/0/%h", i, resp_valid, req_ready, resp_data, want);
            end
            tick();
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got valid=%b ready=%b want 0/1", resp_valid, req_ready); end
    endtask

    task automatic test_reset_mid();
        avm_waitrequest = 1'b1;
        req_data  = mk_req(64'h50, 32'h0, 8'h11, 16'h2222, 4'hF, 1'b0);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        checks++; if (avm_read !== 1'b1) begin errors++; $display("FAIL rstmid_cmd: got %b want 1", avm_read); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (avm_read !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL rstmid_async: got rd=%b ready=%b want 0/0", avm_read, req_ready); end
        checks++; if (stat_dropped !== 16'd0) begin errors++; $display("FAIL rstmid_stat: got %0d want 0", stat_dropped); end
        tick();
        tick();
        reset_n         = 1'b1;
        avm_waitrequest = 1'b0;
        tick();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", req_ready); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (resp_valid !== 1'b0 || avm_read !== 1'b0) begin errors++; $display("FAIL rstmid_quiet: cycle %0d got valid=%b rd=%b", i, resp_valid, avm_read); end
            tick();
        end
    endtask

`ifdef FEJKON_MEM_ACCESS_TIMEOUT_EN
    task automatic test_timeout();
        req_data  = mk_req(64'h30, 32'h0, 8'h33, 16'h4444, 4'hF, 1'b0);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL to_early: cycle %0d got %b want 0", i, resp_valid); end
            tick();
        end
        checks++; if (resp_valid !== 1'b1 || resp_data !== exp_resp(32'hFFFF_FFFF, 8'h33, 16'h4444, 7'h30, 2'b10)) begin
            errors++; $display("FAIL to_resp: got valid=%b data=%h", resp_valid, resp_data);
        end
        resp_ready = 1'b1;
        tick();
        req_data  = mk_req(64'h34, 32'h0, 8'h35, 16'h4444, 4'hF, 1'b0);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        avm_readdata      = 32'hBAD0BAD0;
        avm_readdatavalid = 1'b1;
        tick();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL to_stale_dropped: got %b want 0", resp_valid); end
        avm_readdata = 32'h600DF00D;
        tick();
        avm_readdatavalid = 1'b0;
        checks++; if (resp_valid !== 1'b1 || resp_data !== exp_resp(32'h600DF00D, 8'h35, 16'h4444, 7'h34, 2'b00)) begin
            errors++; $display("FAIL to_next_read: got valid=%b data=%h", resp_valid, resp_data);
        end
        tick();
        resp_ready = 1'b0;
    endtask
`endif

    initial begin
        req_data          = '0;
        req_valid         = 1'b0;
        resp_ready        = 1'b0;
        avm_waitrequest   = 1'b0;
        avm_readdata      = '0;
        avm_readdatavalid = 1'b0;
        avm_response      = 2'b00;
        test_reset();
        test_read();
        test_write();
        test_out_of_range();
        test_back_to_back();
        test_resp_backpressure();
        test_reset_mid();
`ifdef FEJKON_MEM_ACCESS_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
